mult_seq_32bit: RTL
===================

Name: mult_seq_32bit

Overview:
- Multi-cycle shift-and-add multiplier for the MIPS datapath's MULT/MULTU path.
- Consumes the 32-bit carry-lookahead adder: one LAC_32bit instance forms each partial sum.
- Produces the 64-bit {hi, lo} product consumed by the HI/LO register stage.
- Sits beside the ALU, downstream of the adder; runs a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured when start is accepted
- b  input  WIDTH  multiplier; captured when start is accepted
- signed_op  input  1  present only with MULT_SIGNED_EN; 1 = MULT, 0 = MULTU
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when hi/lo become valid
- hi  output  WIDTH  upper product word
- lo  output  WIDTH  lower product word

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, multiplicand register=0.
- rst overrides everything. Asserting it mid-operation aborts the operation; no done pulse is issued.
- States: IDLE, RUN, FIX (only with MULT_SIGNED_EN), DONE.
- IDLE, start=1:
  - mcand <= a; hi <= 0; lo <= b; count <= 0; go to RUN.
  - busy rises the next cycle.
- IDLE, start=0: hold; hi/lo keep the last result.
- RUN, per cycle:
  - If lo[0]=1: {c, sum} = hi + mcand through the adder with cin=0.
  - Otherwise: c=0, sum=hi.
  - {hi, lo} <= {c, sum, lo[WIDTH-1:1]}; count <= count+1.
  - After the WIDTH-th iteration (count==WIDTH-1) go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- hi/lo are held stable from DONE until the next accepted start.
- start asserted while busy or in DONE is ignored, not queued.
  - start in DONE is ignored; it is accepted only once back in IDLE.
- Unsigned latency: start sampled at edge 0; done is high in the cycle following edge 32. Back-to-back issue: one op per 34 cycles.
- busy is high in RUN and FIX.
- hi/lo are intermediate during RUN; consumers must qualify them with done.
- Zero operands take no shortcut: latency is fixed and data-independent.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - signed_op port exists.
  - At accept with signed_op=1: mcand <= |a| and lo <= |b| (two's complement magnitude); record neg = a[31]^b[31].
  - After RUN, go to FIX for one cycle. FIX negates the 64-bit {hi, lo} if neg=1, otherwise passes it through; then go to DONE.
  - Signed ops take one extra cycle (done in the cycle after edge 33) whether or not negation was needed.
  - signed_op=0 follows the unsigned path exactly (no FIX).
  - 0x80000000 operands: magnitude 0x80000000 is treated as unsigned; the result is correct modulo 2^64.
- Undefined: no signed_op port, no FIX state; all operations are unsigned.

Decomposition:
- Shared package/header mips_mult_pkg:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIX=2'd2, ST_DONE=2'd3.
  - MULT_WIDTH=32, MULT_CNT_W=6.
- One natural sub-module: the existing LAC_32bit adder, instantiated once for the partial sum. Its cout is the shifted-in carry.
- The FIX negation uses a local 64-bit increment; it does not add a second adder instance.

Test Plan:
- Reset: assert rst mid-RUN (count=10) → next cycle busy=0, done=0, hi=0, lo=0; no done pulse follows.
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, start one cycle → done after exactly 32 cycles; hi=0xFFFFFFFE, lo=0x00000001.
- Carry path: a=0x00010000, b=0x00010000 → hi=0x00000001, lo=0x00000000. Then a=7, b=6 → hi=0, lo=0x0000002A.
- Ignored start: hold start=1 throughout a run with changing a/b → only the first operands are used; exactly one done pulse; hi/lo stable until the next accept.
- Unsigned wrap: MULTU a=0xFFFFFFFD, b=5 → hi=0x00000004, lo=0xFFFFFFF1.
- MULT_SIGNED_EN: signed_op=1, a=0xFFFFFFFD (-3), b=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1. signed_op=1, a=-3, b=-5 → hi=0, lo=0x0000000F.

Source files
------------

// File: rtl/mips_mult_pkg.sv
// Shared encodings and constants for the sequential MIPS multiplier.
// Defines the FSM state type and the operand magnitude helper.
package mips_mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's complement magnitude; 0x80000000 maps to itself and is read as unsigned.
  function automatic logic [MULT_WIDTH-1:0] mag(input logic [MULT_WIDTH-1:0] v);
    logic [MULT_WIDTH-1:0] r;
    if (v[MULT_WIDTH-1]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/LAC_32bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained on group G/P.
module LAC_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [32:0] c_s;
  logic [7:0]  gg_s;
  logic [7:0]  gp_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Per-group lookahead carries, with the group carry-out feeding the next group.
  always_comb begin
    c_s    = '0;
    gg_s   = '0;
    gp_s   = '0;
    c_s[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      c_s[4*grp+1] = g_s[4*grp] | (p_s[4*grp] & c_s[4*grp]);
      c_s[4*grp+2] = g_s[4*grp+1] | (p_s[4*grp+1] & g_s[4*grp])
                   | (p_s[4*grp+1] & p_s[4*grp] & c_s[4*grp]);
      c_s[4*grp+3] = g_s[4*grp+2] | (p_s[4*grp+2] & g_s[4*grp+1])
                   | (p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp])
                   | (p_s[4*grp+2] & p_s[4*grp+1] & p_s[4*grp] & c_s[4*grp]);
      gg_s[grp]    = g_s[4*grp+3] | (p_s[4*grp+3] & g_s[4*grp+2])
                   | (p_s[4*grp+3] & p_s[4*grp+2] & g_s[4*grp+1])
                   | (p_s[4*grp+3] & p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp]);
      gp_s[grp]    = &p_s[4*grp +: 4];
      c_s[4*grp+4] = gg_s[grp] | (gp_s[grp] & c_s[4*grp]);
    end
  end

  assign sum  = p_s ^ c_s[31:0];
  assign cout = c_s[32];

endmodule

// File: rtl/mult_seq_32bit.sv
// Shift-and-add multiplier producing {hi, lo}; one operand bit per cycle through LAC_32bit.
// Define MULT_SIGNED_EN to add the signed_op port and the FIX (result negation) state.
module mult_seq_32bit
  import mips_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
`ifdef MULT_SIGNED_EN
  logic             fix_r;
  logic             neg_r;
`endif

  // Gating the addend (rather than muxing the sum) keeps cout at 0 when lo[0]=0.
  always_comb begin
    addend_s = '0;
    if (lo[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = '0;
    end
  end

  LAC_32bit u_lac (
    .a    (hi),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count_r <= '0;
      mcand_r <= '0;
`ifdef MULT_SIGNED_EN
      fix_r   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef MULT_SIGNED_EN
            if (signed_op) begin
              mcand_r <= mag(a);
              lo      <= mag(b);
              neg_r   <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              mcand_r <= a;
              lo      <= b;
              neg_r   <= 1'b0;
            end
            fix_r   <= signed_op;
`else
            mcand_r <= a;
            lo      <= b;
`endif
            hi      <= '0;
            count_r <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          {hi, lo} <= {cout_s, sum_s, lo[WIDTH-1:1]};
          count_r  <= count_r + CNT_W'(1);
          if (count_r == CNT_W'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
            if (fix_r) begin
              state_r <= ST_FIX;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end
`else
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        ST_FIX: begin
          // Local 64-bit negate; the shared adder is not reused here.
          if (neg_r) begin
            {hi, lo} <= ~{hi, lo} + (2*WIDTH)'(1);
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
`endif
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
